spi_reg_periph: RTL and testbench

SPI_REG_PERIPH -- requirements
Module: spi_reg_periph

---
 rtl/spi_reg_periph.sv | 188 ++++++++++++++++++
 tb/tb_spi_reg_periph.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_periph.sv
// SPI mode-0 peripheral exposing a small writable register file, oversampled in the clk domain.
// Optional read path: define SPI_REG_PERIPH_READBACK_EN to enable register readback on cipo.
module spi_reg_periph #(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic                         wr_strobe,
    output logic                         frame_err
);

    localparam int unsigned FRAME_L = 8 + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_L + 2);
    localparam int unsigned REGS_W  = NUM_REGS * DATA_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    logic [1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
    logic       sclk_hist_q, ncs_hist_q;
    logic       sclk_s, ncs_s, copi_s;
    logic       sclk_rise, ncs_rise, ncs_fall, bit_smp, addr_ok;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          hdr_q, hdr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [REGS_W-1:0]   regs_q, regs_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic                frame_err_q, frame_err_d;

    // Input synchronisers; idle values chosen so reset release with ncs high shows no edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            ncs_sync_q  <= 2'b11;
            copi_sync_q <= 2'b00;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], sclk};
            ncs_sync_q  <= {ncs_sync_q[0], ncs};
            copi_sync_q <= {copi_sync_q[0], copi};
            sclk_hist_q <= sclk_sync_q[1];
            ncs_hist_q  <= ncs_sync_q[1];
        end
    end

    assign sclk_s    = sclk_sync_q[1];
    assign ncs_s     = ncs_sync_q[1];
    assign copi_s    = copi_sync_q[1];
    assign sclk_rise = sclk_s && !sclk_hist_q;
    assign ncs_rise  = ncs_s && !ncs_hist_q;
    assign ncs_fall  = !ncs_s && ncs_hist_q;
    assign bit_smp   = sclk_rise && !ncs_s;
    assign addr_ok   = 32'(hdr_q[6:0]) < NUM_REGS;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hdr_q       <= '0;
            rx_q        <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            rx_q        <= rx_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Frame FSM: ncs edges dominate; otherwise each sampled bit advances the frame
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hdr_d       = hdr_q;
        rx_d        = rx_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        frame_err_d = 1'b0;

        if (ncs_rise) begin
            state_d = S_IDLE;
            if (state_q != S_IDLE) begin
                if (cnt_q != CNT_W'(FRAME_L)) begin
                    frame_err_d = 1'b1;
                end else if (hdr_q[7] && addr_ok) begin
                    wr_strobe_d = 1'b1;
                    for (int unsigned k = 0; k < NUM_REGS; k++) begin
                        if (hdr_q[6:0] == 7'(k)) begin
                            regs_d[k*DATA_W +: DATA_W] = rx_q;
                        end
                    end
                end
            end
        end else if (ncs_fall) begin
            state_d = S_HDR;
            cnt_d   = '0;
        end else if (bit_smp) begin
            case (state_q)
                S_HDR: begin
                    hdr_d = {hdr_q[6:0], copi_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(8)) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    rx_d  = {rx_q[DATA_W-2:0], copi_s};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(FRAME_L)) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != CNT_W'(FRAME_L + 1)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

`ifdef SPI_REG_PERIPH_READBACK_EN
    logic              sclk_fall, rd_active_d, cipo_q, cipo_oe_q;
    logic [DATA_W-1:0] sh_q, sh_d, rd_word;

    assign sclk_fall = !sclk_s && sclk_hist_q;

    // Load at header end; shift only on falls that follow a sampled data bit so the MSB is held
    always_comb begin
        rd_word = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (hdr_d[6:0] == 7'(k)) begin
                rd_word = regs_q[k*DATA_W +: DATA_W];
            end
        end
        sh_d = sh_q;
        if (state_q == S_HDR && state_d == S_DATA && !hdr_d[7]) begin
            sh_d = rd_word;
        end else if (state_q == S_DATA && sclk_fall && cnt_q > CNT_W'(8)) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end
        rd_active_d = (state_d == S_DATA) && !hdr_d[7];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q      <= '0;
            cipo_q    <= 1'b0;
            cipo_oe_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            cipo_oe_q <= rd_active_d;
            cipo_q    <= rd_active_d & sh_d[DATA_W-1];
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = cipo_oe_q;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_periph.sv
// Bench for spi_reg_periph: two instances (8-bit/5 regs and 16-bit/8 regs) on a shared SPI bus,
// directed plus random frames checked against a frame-level model of the register file.
module tb_spi_reg_periph;

    localparam int unsigned NR0  = 5;
    localparam int unsigned DW0  = 8;
    localparam int unsigned NR1  = 8;
    localparam int unsigned DW1  = 16;
    localparam int unsigned HALF = 8;
`ifdef SPI_REG_PERIPH_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic copi  = 1'b0;
    logic ncs0  = 1'b1;
    logic ncs1  = 1'b1;
    logic cipo0, oe0, wr0, fe0, cipo1, oe1, wr1, fe1;
    logic [NR0*DW0-1:0] regs0;
    logic [NR1*DW1-1:0] regs1;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_seen[2];
    int fe_seen[2];
    int exp_wr[2];
    int exp_fe[2];
    logic [127:0] exp_regs[2];

    spi_reg_periph #(.NUM_REGS(NR0), .DATA_W(DW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs0), .copi(copi),
        .cipo(cipo0), .cipo_oe(oe0), .regs(regs0), .wr_strobe(wr0), .frame_err(fe0)
    );

    spi_reg_periph #(.NUM_REGS(NR1), .DATA_W(DW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs1), .copi(copi),
        .cipo(cipo1), .cipo_oe(oe1), .regs(regs1), .wr_strobe(wr1), .frame_err(fe1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr0) wr_seen[0]++;
        if (fe0) fe_seen[0]++;
        if (wr1) wr_seen[1]++;
        if (fe1) fe_seen[1]++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned dw_of(input int d);
        return (d == 0) ? DW0 : DW1;
    endfunction

    function automatic int unsigned nr_of(input int d);
        return (d == 0) ? NR0 : NR1;
    endfunction

    function automatic logic [127:0] regs_of(input int d);
        return (d == 0) ? 128'(regs0) : regs1;
    endfunction

    task automatic set_ncs(input int d, input logic v);
        if (d == 0) ncs0 = v;
        else ncs1 = v;
    endtask

    // Drive n bits MSB first, sampling cipo/cipo_oe just before each rising sclk
    task automatic spi_xfer(input int d, input int n, input logic [63:0] bits,
                            output logic [63:0] smp_cipo, output logic [63:0] smp_oe);
        smp_cipo = '0;
        smp_oe   = '0;
        @(negedge clk);
        set_ncs(d, 1'b0);
        repeat (HALF) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            sclk = 1'b0;
            copi = bits[i];
            repeat (HALF) @(negedge clk);
            smp_cipo = {smp_cipo[62:0], (d == 0) ? cipo0 : cipo1};
            smp_oe   = {smp_oe[62:0], (d == 0) ? oe0 : oe1};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        set_ncs(d, 1'b1);
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Model: a frame of exactly L bits is a write or read; any other length is an error
    task automatic run_frame(input int d, input int n, input logic [63:0] bits, input string tag);
        logic [63:0] sc, so, exp_sc, exp_so;
        logic [7:0]  hdr;
        logic [15:0] data, rd;
        int unsigned dw, nr, l, a;
        dw = dw_of(d);
        nr = nr_of(d);
        l  = 8 + dw;
        spi_xfer(d, n, bits, sc, so);
        if (n != int'(l)) begin
            exp_fe[d]++;
        end else begin
            hdr  = 8'(bits >> dw);
            data = 16'(bits & ((64'd1 << dw) - 64'd1));
            a    = 32'(hdr[6:0]);
            rd   = '0;
            if (a < nr) begin
                for (int b = 0; b < int'(dw); b++) rd[b] = exp_regs[d][a * dw + 32'(b)];
            end
            if (hdr[7] && a < nr) begin
                for (int b = 0; b < int'(dw); b++) exp_regs[d][a * dw + 32'(b)] = data[b];
                exp_wr[d]++;
            end
            exp_sc = (!hdr[7] && RB) ? 64'(rd) : 64'd0;
            exp_so = (!hdr[7] && RB) ? ((64'd1 << dw) - 64'd1) : 64'd0;
            check_eq({tag, "/cipo_bits"}, 128'(sc), 128'(exp_sc));
            check_eq({tag, "/oe_bits"}, 128'(so), 128'(exp_so));
        end
        check_eq({tag, "/regs"}, regs_of(d), exp_regs[d]);
        check_eq({tag, "/wr_cnt"}, 128'(wr_seen[d]), 128'(exp_wr[d]));
        check_eq({tag, "/fe_cnt"}, 128'(fe_seen[d]), 128'(exp_fe[d]));
        check_eq({tag, "/oe_idle"}, 128'({oe0, oe1, cipo0, cipo1}), 128'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "/regs0"}, 128'(regs0), 128'd0);
        check_eq({tag, "/regs1"}, regs1, 128'd0);
        check_eq({tag, "/outs"}, 128'({cipo0, oe0, wr0, fe0, cipo1, oe1, wr1, fe1}), 128'd0);
    endtask

    initial begin
        int          d, n, sel;
        int unsigned dw, nr, l;
        logic [6:0]  addr;
        logic        rw;
        logic [63:0] frame, bits, pre;

        exp_regs[0] = '0;
        exp_regs[1] = '0;
        for (int i = 0; i < 2; i++) begin
            wr_seen[i] = 0; fe_seen[i] = 0; exp_wr[i] = 0; exp_fe[i] = 0;
        end

        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(0, 16, 64'h80A5, "w_a0");
        run_frame(0, 16, 64'h0000, "rd_a0");
        run_frame(0, 16, 64'h843C, "w_a4");
        run_frame(0, 16, 64'h85FF, "w_a5_oor");
        run_frame(0, 12, 64'h81A, "short12");
        run_frame(0, 17, 64'h102B5, "long17");
        run_frame(1, 24, 64'h87BEEF, "w16_a7");
        run_frame(1, 24, 64'h070000, "rd16_a7");

        // Reset in the middle of a write to address 2
        pre = 64'h82C3;
        @(negedge clk);
        ncs0 = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 15; i >= 6; i--) begin
            sclk = 1'b0;
            copi = pre[i];
            repeat (HALF) @(negedge clk);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        sclk = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        ncs0 = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("midrst");
        exp_regs[0] = '0;
        exp_regs[1] = '0;
        rst_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        check_eq("midrst/fe_cnt", 128'(fe_seen[0]), 128'(exp_fe[0]));
        check_eq("midrst/wr_cnt", 128'(wr_seen[0]), 128'(exp_wr[0]));
        run_frame(0, 16, 64'h82C3, "w_a2_post_rst");

        for (int t = 0; t < 24; t++) begin
            d     = int'($urandom_range(0, 1));
            dw    = dw_of(d);
            nr    = nr_of(d);
            l     = 8 + dw;
            addr  = 7'($urandom_range(0, nr + 2));
            rw    = 1'($urandom_range(0, 1));
            frame = (64'({rw, addr}) << dw) | (64'($urandom) & ((64'd1 << dw) - 64'd1));
            sel   = int'($urandom_range(0, 5));
            if (sel == 0) begin
                n    = int'($urandom_range(1, l - 1));
                bits = frame >> (int'(l) - n);
            end else if (sel == 1) begin
                n    = int'(l) + int'($urandom_range(1, 3));
                bits = (frame << (n - int'(l))) | 64'($urandom_range(0, 7) & ((1 << (n - int'(l))) - 1));
            end else begin
                n    = int'(l);
                bits = frame;
            end
            run_frame(d, n, bits, $sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
